// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
//   mult/multu finish after MUL_LAT busy cycles, div/divu after 32 busy
//   cycles (radix-2 restoring, one quotient bit per cycle). mthi/mtlo write
//   HI/LO in one edge; mfhi/mflo are combinational reads.
//
// Handshake: an operation is accepted on a rising edge where start=1, the
//   unit is idle (busy=0) and mdu_op is a mult/div/mthi/mtlo code. Any start
//   seen while busy=1 is dropped. No back-pressure beyond busy.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   qualifies mdu_op
//   mdu_op   in   [3:0] 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                 7 mfhi, 8 mflo, others none
//   A, B     in   [31:0] rs / rt operands
//   busy     out  operation in progress
//   mdu_out  out  [31:0] HI for mfhi, LO for mflo, else 0
//   hi, lo   out  [31:0] current HI / LO registers
module mul_div_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    // Counter loads "cycles remaining - 1"; the commit happens when it is 0.
    localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_LAST = 5'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [63:0] prod;

    // Divider working registers: rem is the partial remainder, quo starts as
    // the dividend magnitude and shifts quotient bits in from the right.
    logic [31:0] dvsr;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        is_signed;
    logic [63:0] mul_a, mul_b;
    logic [31:0] abs_a, abs_b;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] step_rem, step_quo;
    logic [31:0] rem_fix, quo_fix;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && (mdu_op == OP_MULT || mdu_op == OP_MULTU))
                    state_next = ST_MUL;
                else if (start && (mdu_op == OP_DIV || mdu_op == OP_DIVU))
                    state_next = ST_DIV;
            end
            ST_MUL:  if (cnt == 5'd0) state_next = ST_IDLE;
            ST_DIV:  if (cnt == 5'd0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state != ST_IDLE);
    end

    // ---------------- operand preparation ----------------
    always_comb begin
        is_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
        // Sign- or zero-extend to 64 bits; the low 64 bits of a 64x64
        // product are then correct for both signed and unsigned operands.
        mul_a = {{32{is_signed & A[31]}}, A};
        mul_b = {{32{is_signed & B[31]}}, B};
        abs_a = (is_signed && A[31]) ? (~A + 32'd1) : A;
        abs_b = (is_signed && B[31]) ? (~B + 32'd1) : B;
    end

    // ---------------- one restoring-division step ----------------
    always_comb begin
        shifted = {rem, quo[31]};
        trial   = shifted - {1'b0, dvsr};
        if (shifted >= {1'b0, dvsr}) begin
            step_rem = trial[31:0];
            step_quo = {quo[30:0], 1'b1};
        end else begin
            step_rem = shifted[31:0];
            step_quo = {quo[30:0], 1'b0};
        end
        // Truncating division: quotient sign is the XOR of operand signs,
        // remainder follows the dividend.
        quo_fix = neg_q ? (~step_quo + 32'd1) : step_quo;
        rem_fix = neg_r ? (~step_rem + 32'd1) : step_rem;
    end

    // ---------------- datapath and HI/LO ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            cnt      <= 5'd0;
            prod     <= 64'd0;
            dvsr     <= 32'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (mdu_op)
                            OP_MULT, OP_MULTU: begin
                                prod <= mul_a * mul_b;
                                cnt  <= MUL_LAST;
                            end
                            OP_DIV, OP_DIVU: begin
                                dvsr     <= abs_b;
                                rem      <= 32'd0;
                                quo      <= abs_a;
                                neg_q    <= is_signed & (A[31] ^ B[31]);
                                neg_r    <= is_signed & A[31];
                                div_zero <= (B == 32'd0);
                                cnt      <= DIV_LAST;
                            end
                            OP_MTHI: hi <= A;
                            OP_MTLO: lo <= A;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt == 5'd0) begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ST_DIV: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    if (cnt == 5'd0) begin
                        if (!div_zero) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- combinational read port ----------------
    always_comb begin
        case (mdu_op)
            OP_MFHI: mdu_out = hi;
            OP_MFLO: mdu_out = lo;
            default: mdu_out = 32'd0;
        endcase
    end

endmodule
